// File: rtl/ysyx_23060240_mem_arbiter.sv
// Shared memory-port arbiter between IFU and LSU.
// One outstanding access: IDLE grants a master (round-robin on ties), REQ drives
// the latched request until memory accepts it, WAIT collects the response or
// times out, RESP pulses the owner's response for one cycle.

// Per-master response holder: captures rdata/err when its access completes and
// keeps them stable until that master's next completion.
module ysyx_23060240_mem_arbiter_resp_hold #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] rdata_in,
  input  logic          err_in,
  output logic [DW-1:0] rdata,
  output logic          err
);

  // Capture the completing access result; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (load) begin
      rdata <= rdata_in;
      err   <= err_in;
    end
  end

endmodule

module ysyx_23060240_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  // IFU
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  output logic [DW-1:0]   ifu_rdata,
  output logic            ifu_resp_err,
  // LSU
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_resp_err,
  // memory
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_resp_err
);

  localparam int MW = DW / 8;
  localparam int TW = $clog2(TIMEOUT + 1);

  // Owner encoding doubles as the response-holder index.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } mem_req_t;

  state_t          state, state_nxt;
  logic            owner, last_owner;
  mem_req_t        req_q, req_sel;
  logic [TW-1:0]   timer;

  logic            grant_ifu, grant_lsu;
  logic            resp_load;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;

  logic [1:0]          load_v;
  logic [1:0][DW-1:0]  hold_rdata;
  logic [1:0]          hold_err;

  // Grant only in IDLE and never while reset is being applied; on a tie the
  // master that did not own the previous access wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == S_IDLE && !rst) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (last_owner == OWN_IFU) grant_lsu = 1'b1;
        else                       grant_ifu = 1'b1;
      end else if (ifu_req_valid) begin
        grant_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  // Request image to latch on grant; IFU accesses are always full-word reads.
  always_comb begin
    req_sel = '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '1};
    if (grant_lsu)
      req_sel = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
  end

  // Next-state and completion result; writes always return zero data.
  always_comb begin
    state_nxt  = state;
    resp_load  = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    case (state)
      S_IDLE: if (grant_ifu || grant_lsu) state_nxt = S_REQ;
      S_REQ:  if (mem_req_ready)          state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_resp_valid) begin
          resp_load  = 1'b1;
          resp_rdata = req_q.wen ? '0 : mem_rdata;
          resp_err   = mem_resp_err;
          state_nxt  = S_RESP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          resp_load  = 1'b1;
          resp_err   = 1'b1;
          state_nxt  = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, ownership, latched request and WAIT timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IFU;
      last_owner <= OWN_IFU;
      req_q      <= '0;
      timer      <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ifu || grant_lsu) begin
        owner      <= grant_lsu ? OWN_LSU : OWN_IFU;
        last_owner <= grant_lsu ? OWN_LSU : OWN_IFU;
        req_q      <= req_sel;
      end
      if (state == S_REQ && mem_req_ready) timer <= '0;
      else if (state == S_WAIT)            timer <= timer + TW'(1);
    end
  end

  // Only the owner's holder captures the result.
  assign load_v[OWN_IFU] = resp_load && (owner == OWN_IFU);
  assign load_v[OWN_LSU] = resp_load && (owner == OWN_LSU);

  for (genvar i = 0; i < 2; i++) begin : g_port
    ysyx_23060240_mem_arbiter_resp_hold #(.DW(DW)) u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (load_v[i]),
      .rdata_in (resp_rdata),
      .err_in   (resp_err),
      .rdata    (hold_rdata[i]),
      .err      (hold_err[i])
    );
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;

  assign ifu_resp_valid = !rst && state == S_RESP && owner == OWN_IFU;
  assign lsu_resp_valid = !rst && state == S_RESP && owner == OWN_LSU;
  assign ifu_rdata      = hold_rdata[OWN_IFU];
  assign ifu_resp_err   = hold_err[OWN_IFU];
  assign lsu_rdata      = hold_rdata[OWN_LSU];
  assign lsu_resp_err   = hold_err[OWN_LSU];

  assign mem_req_valid  = !rst && state == S_REQ;
  assign mem_addr       = req_q.addr;
  assign mem_wen        = req_q.wen;
  assign mem_wdata      = req_q.wdata;
  assign mem_wmask      = req_q.wmask;

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter (TIMEOUT = 8).
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
module tb_ysyx_23060240_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ysyx_23060240_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;

    // reset state
    cyc(); cyc(); #1;
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_ifu_ready", ifu_req_ready, 0);
    chk("rst_lsu_ready", lsu_req_ready, 0);
    chk("rst_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("rst_mem_fields", {mem_addr, mem_wen, mem_wmask}, 0);
    chk("rst_rdata_err", {ifu_rdata, ifu_resp_err, lsu_rdata, lsu_resp_err}, 0);

    // tie after reset: LSU write first, then IFU
    cyc(); rst = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h1234_5678; #1;
    chk("t2_lsu_grant", lsu_req_ready, 1);
    chk("t2_ifu_no_grant", ifu_req_ready, 0);
    cyc(); lsu_req_valid = 0; #1;
    chk("t2_mem_req_valid", mem_req_valid, 1);
    chk("t2_mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, {32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF});
    chk("t2_no_ready_in_req", ifu_req_ready, 0);
    cyc(); #1;
    cyc(); ifu_req_valid = 1; #1;
    chk("t2_lsu_resp", {lsu_resp_valid, lsu_rdata, lsu_resp_err}, {1'b1, 32'h0, 1'b0});
    chk("t2_ifu_no_resp", ifu_resp_valid, 0);
    chk("t2_no_ready_in_resp", ifu_req_ready, 0);
    cyc(); #1;
    chk("t2_ifu_grant", ifu_req_ready, 1);
    cyc(); #1;
    chk("t2_ifu_mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, {32'h8000_0004, 1'b0, 32'h0, 4'hF});
    cyc(); #1;
    cyc(); ifu_req_valid = 0; #1;
    chk("t2_ifu_resp", {ifu_resp_valid, ifu_rdata, lsu_resp_valid}, {1'b1, 32'h1234_5678, 1'b0});
    chk("t2_lsu_rdata_held", lsu_rdata, 32'h0);

    // IFU only, minimum latency
    cyc(); ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_resp_valid = 0; #1;
    chk("t1_ifu_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
    cyc(); ifu_req_valid = 0; #1;
    chk("t1_mem_req", {mem_req_valid, mem_addr}, {1'b1, 32'h8000_0000});
    cyc(); mem_resp_valid = 1; mem_rdata = 32'h0000_0413; #1;
    chk("t1_wait_no_req", mem_req_valid, 0);
    cyc(); mem_resp_valid = 0; #1;
    chk("t1_resp", {ifu_resp_valid, ifu_rdata, ifu_resp_err}, {1'b1, 32'h0000_0413, 1'b0});
    chk("t1_lsu_quiet", lsu_resp_valid, 0);
    cyc(); #1;
    chk("t1_resp_pulse_end", {ifu_resp_valid, ifu_rdata}, {1'b0, 32'h0000_0413});

    // both valid continuously: grants alternate starting with LSU
    ifu_addr = 32'h8000_0600; lsu_addr = 32'h8000_0500; lsu_wen = 0;
    mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      cyc(); ifu_req_valid = 1; lsu_req_valid = 1; #1;
      chk($sformatf("t3_grant%0d", i), {lsu_req_ready, ifu_req_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      cyc(); #1;
      chk($sformatf("t3_addr%0d", i), mem_addr, (i % 2 == 0) ? 32'h8000_0500 : 32'h8000_0600);
      cyc(); #1;
      cyc();
      if (i == 5) begin ifu_req_valid = 0; lsu_req_valid = 0; end
      #1;
      chk($sformatf("t3_resp%0d", i), {lsu_resp_valid, ifu_resp_valid}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end

    // memory not ready for 5 cycles: request held stable, nothing accepted
    cyc(); ifu_req_valid = 1; ifu_addr = 32'h8000_0700;
    mem_req_ready = 0; mem_rdata = 32'h0000_ABCD; #1;
    chk("t4_grant", ifu_req_ready, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(); ifu_req_valid = 0; lsu_req_valid = 1; #1;
      chk($sformatf("t4_stall%0d", i), {mem_req_valid, mem_addr, mem_wen, mem_wmask, ifu_req_ready, lsu_req_ready},
          {1'b1, 32'h8000_0700, 1'b0, 4'hF, 1'b0, 1'b0});
    end
    cyc(); mem_req_ready = 1; lsu_req_valid = 0; #1;
    chk("t4_still_req", mem_req_valid, 1);
    cyc(); #1;
    cyc(); #1;
    chk("t4_resp", {ifu_resp_valid, ifu_rdata}, {1'b1, 32'h0000_ABCD});

    // timeout after 8 WAIT cycles, late response ignored
    cyc(); lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0; mem_resp_valid = 0; #1;
    chk("t5_grant", lsu_req_ready, 1);
    cyc(); lsu_req_valid = 0; #1;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      chk($sformatf("t5_wait%0d", i), {lsu_resp_valid, ifu_resp_valid}, 2'b00);
    end
    cyc(); #1;
    chk("t5_timeout_resp", {lsu_resp_valid, lsu_rdata, lsu_resp_err}, {1'b1, 32'h0, 1'b1});
    chk("t5_ifu_held", {ifu_resp_valid, ifu_rdata}, {1'b0, 32'h0000_ABCD});
    cyc(); #1;
    chk("t5_after_resp", lsu_resp_valid, 0);
    cyc(); mem_resp_valid = 1; mem_rdata = 32'h5555_5555; #1;
    chk("t5_late_ignored", {lsu_resp_valid, ifu_resp_valid, mem_req_valid}, 3'b000);
    cyc(); mem_resp_valid = 0; #1;
    chk("t5_late_ignored2", {lsu_resp_valid, ifu_resp_valid, lsu_rdata, lsu_resp_err}, {2'b00, 32'h0, 1'b1});

    // reset during WAIT aborts the access
    cyc(); ifu_req_valid = 1; ifu_addr = 32'h8000_0300; #1;
    chk("t6_grant", ifu_req_ready, 1);
    cyc(); ifu_req_valid = 0; #1;
    cyc(); #1;
    cyc(); rst = 1; #1;
    chk("t6_rst_outputs", {mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}, 5'b0);
    cyc(); rst = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0400; #1;
    chk("t6_cleared", {ifu_rdata, ifu_resp_err, lsu_rdata, lsu_resp_err, mem_addr}, 0);
    chk("t6_regrant", ifu_req_ready, 1);
    cyc(); ifu_req_valid = 0; #1;
    chk("t6_mem_req", {mem_req_valid, mem_addr}, {1'b1, 32'h8000_0400});
    cyc(); mem_resp_valid = 1; mem_rdata = 32'hCAFE_0001; #1;
    cyc(); mem_resp_valid = 0; #1;
    chk("t6_resp", {ifu_resp_valid, ifu_rdata, ifu_resp_err, lsu_resp_valid}, {1'b1, 32'hCAFE_0001, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
